// File: rtl/mult_div_pkg.sv
// Shared types and opcodes for the iterative multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'd0,
    MULT  = 2'd1,
    DIVU  = 2'd2,
    DIV   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: shift-add (multiply, LSB first) or restoring
// trial-subtract (divide, MSB first) on the (upper, lower) register pair.
module mult_div_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] up_i,
  input  logic [WIDTH-1:0] lw_i,
  output logic [WIDTH-1:0] up_o,
  output logic [WIDTH-1:0] lw_o
);

  logic [WIDTH:0] sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, up_i} + (lw_i[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted = {up_i, lw_i[WIDTH-1]};
    // The top bit of diff is set exactly when the trial subtraction underflows.
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      if (diff[WIDTH]) begin
        up_o = shifted[WIDTH-1:0];
        lw_o = {lw_i[WIDTH-2:0], 1'b0};
      end else begin
        up_o = diff[WIDTH-1:0];
        lw_o = {lw_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      up_o = sum[WIDTH:1];
      lw_o = {sum[0], lw_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; STEP_BITS iterations
// per cycle over a shared unsigned-magnitude datapath, signs fixed at the end.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / STEP_BITS;
  localparam int CW = $clog2(N + 1);

  if (WIDTH % STEP_BITS != 0) begin : g_bad_step
    $error("mult_div_seq: STEP_BITS must divide WIDTH");
  end

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [WIDTH-1:0] up_q, up_d, lw_q, lw_d, opd_q, opd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, div0_q, div0_d;

  logic                          is_div;
  logic [STEP_BITS:0][WIDTH-1:0] ch_up, ch_lw;

  assign is_div   = (op_q == DIVU) || (op_q == DIV);
  assign ch_up[0] = up_q;
  assign ch_lw[0] = lw_q;

  for (genvar i = 0; i < STEP_BITS; i++) begin : g_step
    mult_div_step #(.WIDTH(WIDTH)) u_step (
      .is_div (is_div),
      .operand(opd_q),
      .up_i   (ch_up[i]),
      .lw_i   (ch_lw[i]),
      .up_o   (ch_up[i+1]),
      .lw_o   (ch_lw[i+1])
    );
  end

  logic             in_sa, in_sb, in_dz;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    in_sa    = op[0] & a[WIDTH-1];
    in_sb    = op[0] & b[WIDTH-1];
    in_dz    = op[1] && (b == '0);
    mag_a    = in_sa ? -a : a;
    mag_b    = in_sb ? -b : b;
    prod     = {up_q, lw_q};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    up_d    = up_q;
    lw_d    = lw_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op_t'(op);
          sa_d   = in_sa;
          sb_d   = in_sb;
          dz_d   = in_dz;
          cnt_d  = CW'(N);
          div0_d = 1'b0;
          up_d   = '0;
          // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
          if (op[1]) begin
            lw_d  = in_dz ? a : mag_a;
            opd_d = mag_b;
          end else begin
            lw_d  = mag_b;
            opd_d = mag_a;
          end
          state_d = in_dz ? FIX : RUN;
        end else begin
          if (writeHi) hi_d = wrData;
          if (writeLo) lo_d = wrData;
        end
      end
      RUN: begin
        up_d  = ch_up[STEP_BITS];
        lw_d  = ch_lw[STEP_BITS];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          hi_d   = lw_q;
          lo_d   = '1;
          div0_d = 1'b1;
        end else if (is_div) begin
          hi_d = sa_q ? -up_q : up_q;
          lo_d = (sa_q ^ sb_q) ? -lw_q : lw_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MULTU;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      up_q    <= '0;
      lw_q    <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      up_q    <= up_d;
      lw_q    <= lw_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign divByZero = div0_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
